adc_scan_ctrl: RTL and testbench

Multi-channel scan scheduler for the single-channel SPI ADC engine (`spi_wr`). It replaces the fixed-command, button-triggered start with a sequence:
- a periodic or one-shot scan trigger;
- one conversion per enabled channel, in ascending channel order;
- capture of each 12-bit result into a per-channel register.

It sits between the SPI engine and the downstream consumer. The SPI engine's `strc_i`, `cmd_i`, `eoc_o` and `dout_o` connect to this block's `strc_o`, `cmd_o`, `eoc_i` and `dout_i`.

---
 rtl/adc_scan_pkg.sv | 35 +++
 rtl/adc_scan_ctrl_scan_timer.sv | 35 +++
 rtl/adc_scan_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_adc_scan_ctrl.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_pkg
// Description : Shared types and constants for the ADC scan scheduler:
//               FSM state encoding, command field widths, command builder.
// Revision    : 1.0 - initial release
// ============================================================================
package adc_scan_pkg;

    // Command byte layout: {START, channel[2:0], mode/SGL/PD nibble}
    localparam int   CH_W      = 3;
    localparam int   CMD_LSB_W = 4;
    localparam int   CMD_W     = 1 + CH_W + CMD_LSB_W;
    localparam int   DATA_W    = 12;
    localparam logic CMD_START = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEEK  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } scan_state_t;

    // Assemble the command byte sent to the SPI engine for one channel
    function automatic logic [CMD_W-1:0] make_cmd(
        input logic [CH_W-1:0]      ch,
        input logic [CMD_LSB_W-1:0] lsb
    );
        return {CMD_START, ch, lsb};
    endfunction

endpackage
`default_nettype wire

// File: rtl/adc_scan_ctrl_scan_timer.sv
`default_nettype none
// ============================================================================
// Module      : scan_timer
// Description : Free-running scan period counter. Emits a tick on the clock
//               where the count equals the programmed period, then wraps.
//               Held at zero while periodic scanning is disabled.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_timer #(
    parameter int PER_W = 29
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic [PER_W-1:0] period_i,
    output logic             tick_o
);

    logic [PER_W-1:0] r_cnt;

    assign tick_o = enable_i && (r_cnt == period_i);

    // Period counter: clear while disabled, wrap on tick, otherwise count up
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else if (!enable_i || tick_o) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : adc_scan_ctrl
// Description : Multi-channel scan scheduler in front of a single-channel SPI
//               ADC engine. On a periodic or one-shot trigger it converts
//               every enabled channel in ascending order and stores each
//               12-bit result in a per-channel register, with a watchdog
//               guarding each conversion.
// Revision    : 1.0 - initial release
// ============================================================================
module adc_scan_ctrl
    import adc_scan_pkg::*;
#(
    parameter int               NUM_CH  = 4,
    parameter logic [3:0]       CMD_LSB = 4'b0111,
    parameter int               PER_W   = 29,
    parameter int               TO_CYC  = 1023
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic [PER_W-1:0]         period_i,
    input  logic                     single_i,
    input  logic [NUM_CH-1:0]        ch_mask_i,
    output logic                     strc_o,
    output logic [CMD_W-1:0]         cmd_o,
    input  logic                     eoc_i,
    input  logic [DATA_W-1:0]        dout_i,
    output logic [DATA_W*NUM_CH-1:0] data_o,
    output logic [NUM_CH-1:0]        valid_o,
    output logic [NUM_CH-1:0]        err_o,
    output logic                     scan_done_o,
    output logic                     busy_o,
    output logic                     overrun_o
);

    localparam int              c_WD_W    = $clog2(TO_CYC + 1);
    localparam logic [c_WD_W-1:0] c_TO_LIM  = TO_CYC[c_WD_W-1:0];
    localparam logic [CH_W-1:0] c_LAST_CH = CH_W'(NUM_CH - 1);

    scan_state_t         r_state;
    logic [CH_W-1:0]     r_ch;
    logic [NUM_CH-1:0]   r_mask;
    logic [NUM_CH-1:0]   r_wvalid;
    logic [NUM_CH-1:0]   r_werr;
    logic [c_WD_W-1:0]   r_wdog;
    logic [DATA_W-1:0]   r_data [NUM_CH];

    logic                r_single_q;
    logic                r_eoc_q;
    logic                r_eoc_rise;
    logic [DATA_W-1:0]   r_dout_q;

    logic                w_tick;
    logic                w_single_rise;
    logic                w_trigger;
    logic                w_ch_last;
    logic                w_ch_en;
    logic [NUM_CH-1:0]   w_ch_oh;

    scan_timer #(
        .PER_W (PER_W)
    ) u_scan_timer (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .period_i (period_i),
        .tick_o   (w_tick)
    );

    assign w_single_rise = single_i & ~r_single_q;
    assign w_trigger     = w_tick | w_single_rise;
    assign w_ch_last     = (r_ch == c_LAST_CH);

    // One-hot decode of the current channel and its mask bit
    always_comb begin
        w_ch_oh = '0;
        w_ch_en = 1'b0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (r_ch == CH_W'(n)) begin
                w_ch_oh[n] = 1'b1;
                w_ch_en    = r_mask[n];
            end
        end
    end

    // Edge detectors; the eoc rise is registered together with its data
    // so the FSM acts on it one clock later with a stable result
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_single_q <= 1'b0;
            r_eoc_q    <= 1'b0;
            r_eoc_rise <= 1'b0;
            r_dout_q   <= '0;
        end else begin
            r_single_q <= single_i;
            r_eoc_q    <= eoc_i;
            r_eoc_rise <= eoc_i & ~r_eoc_q;
            r_dout_q   <= dout_i;
        end
    end

    // Scan sequencer with registered outputs
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= ST_IDLE;
            r_ch        <= '0;
            r_mask      <= '0;
            r_wvalid    <= '0;
            r_werr      <= '0;
            r_wdog      <= '0;
            strc_o      <= 1'b0;
            cmd_o       <= '0;
            valid_o     <= '0;
            err_o       <= '0;
            scan_done_o <= 1'b0;
            busy_o      <= 1'b0;
            overrun_o   <= 1'b0;
            for (int n = 0; n < NUM_CH; n++) begin
                r_data[n] <= '0;
            end
        end else begin
            strc_o      <= 1'b0;
            scan_done_o <= 1'b0;
            overrun_o   <= w_trigger && (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (w_trigger) begin
                        r_mask   <= ch_mask_i;
                        r_wvalid <= '0;
                        r_werr   <= '0;
                        r_ch     <= '0;
                        busy_o   <= 1'b1;
                        r_state  <= ST_SEEK;
                    end
                end

                ST_SEEK: begin
                    if (w_ch_en) begin
                        r_state <= ST_START;
                    end else if (w_ch_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end

                ST_START: begin
                    cmd_o   <= make_cmd(r_ch, CMD_LSB);
                    strc_o  <= 1'b1;
                    r_wdog  <= '0;
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_eoc_rise) begin
                        for (int n = 0; n < NUM_CH; n++) begin
                            if (w_ch_oh[n]) begin
                                r_data[n] <= r_dout_q;
                            end
                        end
                        r_wvalid <= r_wvalid | w_ch_oh;
                        r_state  <= ST_NEXT;
                    end else if (r_wdog == c_TO_LIM) begin
                        // Slot keeps its previous result on timeout
                        r_werr  <= r_werr | w_ch_oh;
                        r_state <= ST_NEXT;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end

                ST_NEXT: begin
                    if (w_ch_last) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_ch    <= r_ch + 1'b1;
                        r_state <= ST_SEEK;
                    end
                end

                ST_DONE: begin
                    valid_o     <= r_wvalid;
                    err_o       <= r_werr;
                    scan_done_o <= 1'b1;
                    busy_o      <= 1'b0;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
            assign data_o[DATA_W*g +: DATA_W] = r_data[g];
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_scan_ctrl
// Description : Directed self-checking bench for adc_scan_ctrl with a
//               behavioural SPI engine stub.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_scan_ctrl;

    logic        clk;
    logic        rst_i;
    logic        enable_i;
    logic [28:0] period_i;
    logic        single_i;
    logic [3:0]  ch_mask_i;
    logic        strc_o;
    logic [7:0]  cmd_o;
    logic        eoc_i;
    logic [11:0] dout_i;
    logic [47:0] data_o;
    logic [3:0]  valid_o;
    logic [3:0]  err_o;
    logic        scan_done_o;
    logic        busy_o;
    logic        overrun_o;

    int errors = 0;
    int checks = 0;

    // Stub control and monitors
    logic [11:0] stub_base = 12'h000;
    logic [3:0]  stub_skip = 4'h8;
    logic [7:0]  cmd_log [64];
    int          strc_cnt = 0;
    int          done_cnt = 0;
    int          ovr_cnt  = 0;
    int          cyc_now  = 0;

    adc_scan_ctrl dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .enable_i    (enable_i),
        .period_i    (period_i),
        .single_i    (single_i),
        .ch_mask_i   (ch_mask_i),
        .strc_o      (strc_o),
        .cmd_o       (cmd_o),
        .eoc_i       (eoc_i),
        .dout_i      (dout_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .err_o       (err_o),
        .scan_done_o (scan_done_o),
        .busy_o      (busy_o),
        .overrun_o   (overrun_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc_now++;
    end

    // Event monitors
    initial forever begin
        @(negedge clk);
        if (strc_o === 1'b1) begin
            if (strc_cnt < 64) cmd_log[strc_cnt] = cmd_o;
            strc_cnt++;
        end
        if (scan_done_o === 1'b1) done_cnt++;
        if (overrun_o === 1'b1) ovr_cnt++;
    end

    // SPI engine stub: answers 40 clocks after a start with base + channel
    initial begin
        logic [2:0] ch;
        forever begin
            @(negedge clk);
            if (strc_o === 1'b1) begin
                ch = cmd_o[6:4];
                if ({1'b0, ch} != stub_skip) begin
                    repeat (40) @(negedge clk);
                    dout_i = stub_base + 12'(ch);
                    eoc_i  = 1'b1;
                    repeat (3) @(negedge clk);
                    eoc_i  = 1'b0;
                end
            end
        end
    end

    task automatic wait_done(input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (scan_done_o === 1'b1) seen = 1'b1;
        end
        if (!seen) cyc = -1;
    endtask

    task automatic pulse_single();
        @(negedge clk);
        single_i = 1'b1;
        @(negedge clk);
        single_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (strc_o !== 1'b0) begin errors++; $display("FAIL reset_strc: got %b want 0", strc_o); end
        checks++; if (cmd_o !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h want 00", cmd_o); end
        checks++; if (data_o !== 48'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
        checks++; if (valid_o !== 4'h0) begin errors++; $display("FAIL reset_valid: got %h want 0", valid_o); end
        checks++; if (err_o !== 4'h0) begin errors++; $display("FAIL reset_err: got %h want 0", err_o); end
        checks++; if ({scan_done_o, busy_o, overrun_o} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {scan_done_o, busy_o, overrun_o}); end
        rst_i = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy_o); end
    endtask

    task automatic test_full_scan();
        int s0, d0, cyc;
        s0 = strc_cnt; d0 = done_cnt;
        stub_base = 12'h100; ch_mask_i = 4'hF;
        @(negedge clk);
        single_i = 1'b1;
        @(negedge clk);
        single_i = 1'b0;
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL full_busy: got %b want 1", busy_o); end
        @(negedge clk);
        checks++; if (strc_o !== 1'b0) begin errors++; $display("FAIL full_strc_early: got %b want 0", strc_o); end
        @(negedge clk);
        checks++; if (strc_o !== 1'b1) begin errors++; $display("FAIL full_strc_t2: got %b want 1", strc_o); end
        wait_done(2000, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL full_done_timeout: got none want scan_done"); end
        checks++; if (strc_cnt - s0 !== 4) begin errors++; $display("FAIL full_strc_count: got %0d want 4", strc_cnt - s0); end
        for (int k = 0; k < 4; k++) begin
            logic [7:0] want;
            want = 8'h87 + 8'(k * 16);
            checks++; if (cmd_log[s0 + k] !== want) begin errors++; $display("FAIL full_cmd%0d: got %h want %h", k, cmd_log[s0 + k], want); end
        end
        checks++; if (data_o !== {12'h103, 12'h102, 12'h101, 12'h100}) begin errors++; $display("FAIL full_data: got %h want 103102101100", data_o); end
        checks++; if (valid_o !== 4'hF) begin errors++; $display("FAIL full_valid: got %h want f", valid_o); end
        checks++; if (err_o !== 4'h0) begin errors++; $display("FAIL full_err: got %h want 0", err_o); end
        @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL full_done_count: got %0d want 1", done_cnt - d0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL full_busy_end: got %b want 0", busy_o); end
    endtask

    task automatic test_partial_mask();
        int s0, cyc;
        s0 = strc_cnt;
        stub_base = 12'h200; ch_mask_i = 4'b0101;
        pulse_single();
        wait_done(2000, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL part_done_timeout: got none want scan_done"); end
        checks++; if (strc_cnt - s0 !== 2) begin errors++; $display("FAIL part_strc_count: got %0d want 2", strc_cnt - s0); end
        checks++; if (cmd_log[s0 + 1] !== 8'hA7) begin errors++; $display("FAIL part_cmd1: got %h want a7", cmd_log[s0 + 1]); end
        checks++; if (data_o !== {12'h103, 12'h202, 12'h101, 12'h200}) begin errors++; $display("FAIL part_data: got %h want 103202101200", data_o); end
        checks++; if (valid_o !== 4'b0101) begin errors++; $display("FAIL part_valid: got %b want 0101", valid_o); end
    endtask

    task automatic test_timeout();
        int cyc;
        stub_base = 12'h300; stub_skip = 4'd2; ch_mask_i = 4'hF;
        pulse_single();
        wait_done(3000, cyc);
        stub_skip = 4'h8;
        checks++; if (cyc < 0) begin errors++; $display("FAIL to_done_timeout: got none want scan_done"); end
        checks++; if (cyc <= 1023) begin errors++; $display("FAIL to_duration: got %0d want >1023", cyc); end
        checks++; if (err_o !== 4'b0100) begin errors++; $display("FAIL to_err: got %b want 0100", err_o); end
        checks++; if (valid_o !== 4'b1011) begin errors++; $display("FAIL to_valid: got %b want 1011", valid_o); end
        checks++; if (data_o !== {12'h303, 12'h202, 12'h301, 12'h300}) begin errors++; $display("FAIL to_data: got %h want 303202301300", data_o); end
    endtask

    task automatic test_mask_zero();
        int s0, cyc;
        bit seen;
        logic [47:0] prev;
        s0 = strc_cnt; prev = data_o; ch_mask_i = 4'h0;
        @(negedge clk);
        single_i = 1'b1;
        cyc = 0; seen = 1'b0;
        while (!seen && cyc < 50) begin
            @(negedge clk);
            single_i = 1'b0;
            cyc++;
            if (scan_done_o === 1'b1) seen = 1'b1;
        end
        checks++; if (cyc !== 6) begin errors++; $display("FAIL zero_latency: got %0d want 6", cyc); end
        checks++; if (strc_cnt - s0 !== 0) begin errors++; $display("FAIL zero_strc: got %0d want 0", strc_cnt - s0); end
        checks++; if ({valid_o, err_o} !== 8'h00) begin errors++; $display("FAIL zero_flags: got %h want 00", {valid_o, err_o}); end
        checks++; if (data_o !== prev) begin errors++; $display("FAIL zero_data: got %h want %h", data_o, prev); end
    endtask

    task automatic test_periodic();
        int d0, o0, cyc, t1, t2, t3, w;
        d0 = done_cnt; o0 = ovr_cnt;
        stub_base = 12'h400; ch_mask_i = 4'hF; period_i = 29'd499;
        @(negedge clk);
        enable_i = 1'b1;
        wait_done(1000, cyc);
        t1 = cyc_now;
        checks++; if (cyc < 0) begin errors++; $display("FAIL per_done1_timeout: got none want scan_done"); end
        checks++; if (data_o !== {12'h403, 12'h402, 12'h401, 12'h400}) begin errors++; $display("FAIL per_data: got %h want 403402401400", data_o); end
        w = 0;
        while (busy_o !== 1'b1 && w < 600) begin @(negedge clk); w++; end
        repeat (10) @(negedge clk);
        pulse_single();
        @(negedge clk);
        checks++; if (ovr_cnt - o0 !== 1) begin errors++; $display("FAIL per_overrun: got %0d want 1", ovr_cnt - o0); end
        wait_done(600, cyc);
        t2 = cyc_now;
        checks++; if (t2 - t1 !== 500) begin errors++; $display("FAIL per_interval: got %0d want 500", t2 - t1); end
        w = 0;
        while (busy_o !== 1'b1 && w < 600) begin @(negedge clk); w++; end
        repeat (5) @(negedge clk);
        enable_i = 1'b0;
        wait_done(600, cyc);
        t3 = cyc_now;
        checks++; if (t3 - t2 !== 500) begin errors++; $display("FAIL per_interval2: got %0d want 500", t3 - t2); end
        repeat (1100) @(negedge clk);
        checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL per_scan_count: got %0d want 3", done_cnt - d0); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL per_stopped: got %b want 0", busy_o); end
    endtask

    task automatic test_reset_mid_wait();
        int s0, cyc, w;
        stub_base = 12'h500; ch_mask_i = 4'hF;
        pulse_single();
        w = 0;
        while (strc_o !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        repeat (10) @(negedge clk);
        rst_i = 1'b0;
        #1;
        checks++; if ({strc_o, busy_o, scan_done_o, overrun_o} !== 4'b0000) begin errors++; $display("FAIL rst_mid_flags: got %b want 0000", {strc_o, busy_o, scan_done_o, overrun_o}); end
        checks++; if (cmd_o !== 8'h00) begin errors++; $display("FAIL rst_mid_cmd: got %h want 00", cmd_o); end
        checks++; if (data_o !== 48'h0) begin errors++; $display("FAIL rst_mid_data: got %h want 0", data_o); end
        checks++; if ({valid_o, err_o} !== 8'h00) begin errors++; $display("FAIL rst_mid_valid: got %h want 00", {valid_o, err_o}); end
        repeat (3) @(negedge clk);
        rst_i = 1'b1;
        repeat (60) @(negedge clk);
        s0 = strc_cnt;
        pulse_single();
        wait_done(2000, cyc);
        checks++; if (cyc < 0) begin errors++; $display("FAIL rst_restart_timeout: got none want scan_done"); end
        checks++; if (cmd_log[s0] !== 8'h87) begin errors++; $display("FAIL rst_restart_cmd: got %h want 87", cmd_log[s0]); end
        checks++; if (valid_o !== 4'hF) begin errors++; $display("FAIL rst_restart_valid: got %h want f", valid_o); end
        checks++; if (data_o !== {12'h503, 12'h502, 12'h501, 12'h500}) begin errors++; $display("FAIL rst_restart_data: got %h want 503502501500", data_o); end
    endtask

    initial begin
        rst_i     = 1'b0;
        enable_i  = 1'b0;
        period_i  = '0;
        single_i  = 1'b0;
        ch_mask_i = '0;
        eoc_i     = 1'b0;
        dout_i    = '0;
        test_reset();
        test_full_scan();
        test_partial_mask();
        test_timeout();
        test_mask_zero();
        test_periodic();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
